// File: rtl/instr_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : instr_sequencer
//  Purpose  : Multi-cycle instruction sequencer for the 9-bit-ISA core. Owns
//             the program counter, steps through EXEC/MEM, stalls on the
//             data-memory handshake with a timeout, detects the halt code and
//             turns decoder write strobes into commit-qualified enables.
//  Ports    : Clk, Reset (async, active-high)
//             Start            - level, (re)starts the program at PC 0
//             Instr            - machine code at PC (combinational ROM read)
//             RegWrite, MemWrite, MemtoReg, Branch - decoder outputs
//             BrTaken, BrTarget - branch condition and destination
//             MemReady         - data-memory completion (only while MemReq)
//             PC               - registered program counter
//             RegWrEn, MemWrEn - qualified write enables (commit cycles only)
//             MemReq           - data-memory access in progress
//             Busy, Done, Err  - status from the state register
//             RetireCnt        - saturating retired-instruction count
//  Revision : 1.0 - initial release
// ============================================================================
module instr_sequencer #(
  parameter int         PCW       = 10,
  parameter logic [8:0] HALT_CODE = 9'h1FF,
  parameter int         TIMEOUT   = 15,
  parameter int         CNTW      = 16
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            Start,
  input  logic [8:0]      Instr,
  input  logic            RegWrite,
  input  logic            MemWrite,
  input  logic            MemtoReg,
  input  logic            Branch,
  input  logic            BrTaken,
  input  logic [PCW-1:0]  BrTarget,
  input  logic            MemReady,
  output logic [PCW-1:0]  PC,
  output logic            RegWrEn,
  output logic            MemWrEn,
  output logic            MemReq,
  output logic            Busy,
  output logic            Done,
  output logic            Err,
  output logic [CNTW-1:0] RetireCnt
);

  localparam int            TW         = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_EXEC = 3'd1,
    S_MEM  = 3'd2,
    S_DONE = 3'd3,
    S_ERR  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic [TW-1:0]   tmo_q, tmo_d;
  logic            reg_wr_en, mem_wr_en, retire;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    tmo_d     = tmo_q;
    reg_wr_en = 1'b0;
    mem_wr_en = 1'b0;
    retire    = 1'b0;

    unique case (state_q)
      S_IDLE, S_DONE, S_ERR: begin
        if (Start) begin
          state_d = S_EXEC;
          pc_d    = '0;
          tmo_d   = '0;
        end
      end

      S_EXEC: begin
        // Halt has priority so the reserved code is never executed as an op.
        if (Instr == HALT_CODE) begin
          state_d = S_DONE;
        end else if (MemtoReg || MemWrite) begin
          // Memory path wins over any branch in the same instruction.
          state_d = S_MEM;
          tmo_d   = '0;
        end else begin
          reg_wr_en = RegWrite;
          retire    = 1'b1;
          pc_d      = (Branch && BrTaken) ? BrTarget : pc_q + PCW'(1);
        end
      end

      S_MEM: begin
        if (MemReady) begin
          // Instr is still addressed by the held PC, so the decoder
          // outputs still describe the pending load or store.
          reg_wr_en = MemtoReg & RegWrite;
          mem_wr_en = MemWrite & ~MemtoReg;
          retire    = 1'b1;
          pc_d      = pc_q + PCW'(1);
          tmo_d     = '0;
          state_d   = S_EXEC;
        end else if (tmo_q == TMO_LAST) begin
          state_d = S_ERR;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      default: state_d = S_IDLE;
    endcase

    if (state_q != S_EXEC && state_q != S_MEM && Start) begin
      cnt_d = '0;
    end else if (retire && !(&cnt_q)) begin
      cnt_d = cnt_q + CNTW'(1);
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q <= S_IDLE;
      pc_q    <= '0;
      cnt_q   <= '0;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
    end
  end

  assign PC        = pc_q;
  assign RetireCnt = cnt_q;
  assign RegWrEn   = reg_wr_en;
  assign MemWrEn   = mem_wr_en;
  assign MemReq    = (state_q == S_MEM);
  assign Busy      = (state_q == S_EXEC) || (state_q == S_MEM);
  assign Done      = (state_q == S_DONE);
  assign Err       = (state_q == S_ERR);

endmodule
`default_nettype wire
